// File: rtl/bcd_scan_display.sv
// bcd_scan_display
//
// Display/accumulation stage of the counter chain. Carry pulses from the
// mod-10 prescaler are accumulated into a 4-digit BCD count (0000..9999).
// The count wraps to 0000 after 9999 and flags each wrap with a one-cycle
// pulse. The count is also shown on a time-multiplexed, common-anode 4-digit
// seven-segment display. Leading zeros can optionally be blanked.
//
// Parameters
//   SCAN_DIV : clock cycles each digit stays selected (>= 1)
//   LZB      : 1 blanks leading zeros on digits 3..1, 0 shows all digits
//
// Ports
//   clk    : single clock, all state updates on its rising edge
//   rstn   : asynchronous active-low reset
//   tick   : count request, each high cycle counts once while en is high
//   en     : count enable
//   clr    : synchronous clear of the count (wins over tick)
//   digits : BCD count {d3,d2,d1,d0}, d0 = units in bits [3:0]
//   ovf    : one-cycle pulse, aligned with the 9999 -> 0000 wrap
//   seg    : segment pattern {g,f,e,d,c,b,a}, active-high
//   an     : digit select, one-hot active-low, an[k] selects dk
module bcd_scan_display #(
   parameter int SCAN_DIV = 4,
   parameter bit LZB      = 1'b1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        tick,
   input  logic        en,
   input  logic        clr,
   output logic [15:0] digits,
   output logic        ovf,
   output logic [6:0]  seg,
   output logic [3:0]  an
);

   localparam int                CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   logic [15:0]      digits_q, digits_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [6:0]       seg_q, seg_d;
   logic [3:0]       an_q, an_d;

   // Per-digit views of the current count.
   logic [3:0] d0, d1, d2, d3;
   assign d0 = digits_q[3:0];
   assign d1 = digits_q[7:4];
   assign d2 = digits_q[11:8];
   assign d3 = digits_q[15:12];

   // Ripple carry of an increment: digit k receives a carry when every lower
   // digit is 9. wrap means the whole count is 9999.
   logic c1, c2, c3, wrap;
   logic [3:0] carry_in;
   assign c1       = (d0 == 4'd9);
   assign c2       = c1 & (d1 == 4'd9);
   assign c3       = c2 & (d2 == 4'd9);
   assign wrap     = c3 & (d3 == 4'd9);
   assign carry_in = {c3, c2, c1, 1'b1};

   function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic cin);
      if (!cin)
         return d;
      else if (d == 4'd9)
         return 4'd0;
      else
         return d + 4'd1;
   endfunction

   // Count update: clear wins over tick; ovf only on the wrapping increment.
   always_comb begin
      digits_d = digits_q;
      ovf_d    = 1'b0;
      if (clr) begin
         digits_d = 16'h0000;
      end else if (tick && en) begin
         digits_d = {bcd_inc(d3, carry_in[3]), bcd_inc(d2, carry_in[2]),
                     bcd_inc(d1, carry_in[1]), bcd_inc(d0, carry_in[0])};
         ovf_d    = wrap;
      end
   end

   // Scan timer: scan_cnt runs 0..SCAN_DIV-1, idx steps on its wrap.
   // With SCAN_DIV=1 the counter is pinned at 0 and idx steps every cycle.
   always_comb begin
      scan_cnt_d = scan_cnt_q + CNT_W'(1);
      idx_d      = idx_q;
      if (scan_cnt_q == CNT_MAX) begin
         scan_cnt_d = '0;
         idx_d      = idx_q + 2'd1;
      end
   end

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   // Leading-zero detection: zk means digits k..3 are all zero.
   logic z1, z2, z3;
   assign z3 = (d3 == 4'd0);
   assign z2 = z3 & (d2 == 4'd0);
   assign z1 = z2 & (d1 == 4'd0);

   // Display registers sample the pre-edge idx and count, so an/seg trail
   // idx and digits by one cycle. d0 is never blanked.
   logic [3:0] sel_digit;
   logic       blank;
   always_comb begin
      sel_digit = digits_q[4*idx_q +: 4];
      blank     = 1'b0;
      if (LZB) begin
         case (idx_q)
            2'd1:    blank = z1;
            2'd2:    blank = z2;
            2'd3:    blank = z3;
            default: blank = 1'b0;
         endcase
      end
      an_d  = ~(4'b0001 << idx_q);
      seg_d = blank ? 7'h00 : seg_decode(sel_digit);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         digits_q   <= 16'h0000;
         ovf_q      <= 1'b0;
         scan_cnt_q <= '0;
         idx_q      <= 2'd0;
         seg_q      <= 7'h3F;
         an_q       <= 4'b1110;
      end else begin
         digits_q   <= digits_d;
         ovf_q      <= ovf_d;
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
      end
   end

   assign digits = digits_q;
   assign ovf    = ovf_q;
   assign seg    = seg_q;
   assign an     = an_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Testbench for bcd_scan_display. Three instances share the same inputs:
//   u_dut  : SCAN_DIV=4, LZB=1
//   u_lz0  : SCAN_DIV=4, LZB=0
//   u_fast : SCAN_DIV=1, LZB=1
// A reference model built from decimal arithmetic tracks the count and the
// expected display of each instance; directed tables and sequences cover the
// corner cases.
module tb_bcd_scan_display;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rstn;
   logic tick, en, clr;

   always #5 clk = ~clk;

   logic [15:0] digits_a, digits_b, digits_c;
   logic        ovf_a, ovf_b, ovf_c;
   logic [6:0]  seg_a, seg_b, seg_c;
   logic [3:0]  an_a, an_b, an_c;

   bcd_scan_display #(.SCAN_DIV(4), .LZB(1'b1)) u_dut (
      .clk(clk), .rstn(rstn), .tick(tick), .en(en), .clr(clr),
      .digits(digits_a), .ovf(ovf_a), .seg(seg_a), .an(an_a));

   bcd_scan_display #(.SCAN_DIV(4), .LZB(1'b0)) u_lz0 (
      .clk(clk), .rstn(rstn), .tick(tick), .en(en), .clr(clr),
      .digits(digits_b), .ovf(ovf_b), .seg(seg_b), .an(an_b));

   bcd_scan_display #(.SCAN_DIV(1), .LZB(1'b1)) u_fast (
      .clk(clk), .rstn(rstn), .tick(tick), .en(en), .clr(clr),
      .digits(digits_c), .ovf(ovf_c), .seg(seg_c), .an(an_c));

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   function automatic int pow10(input int i);
      int r = 1;
      for (int k = 0; k < i; k++) r = r * 10;
      return r;
   endfunction

   function automatic logic [6:0] seg_code(input int d);
      logic [6:0] tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      return tab[d];
   endfunction

   function automatic logic [15:0] to_bcd(input int count);
      return {4'((count / 1000) % 10), 4'((count / 100) % 10),
              4'((count / 10) % 10), 4'(count % 10)};
   endfunction

   // t = clock edges since reset before the edge being modelled.
   function automatic logic [3:0] exp_an(input int t, input int div);
      logic [3:0] r = 4'b1111;
      r[(t / div) % 4] = 1'b0;
      return r;
   endfunction

   function automatic logic [6:0] exp_seg(input int count, input int t,
                                          input int div, input bit lzb);
      int idx = (t / div) % 4;
      int p   = pow10(idx);
      if (lzb && idx > 0 && count < p) return 7'h00;
      return seg_code((count / p) % 10);
   endfunction

   function automatic int next_count(input int count, input logic c,
                                     input logic t, input logic e);
      if (c) return 0;
      if (t && e) return (count + 1) % 10000;
      return count;
   endfunction

   int         m_count, m_t;
   logic       m_ovf;
   logic [6:0] m_seg_a, m_seg_b, m_seg_c;
   logic [3:0] m_an_a, m_an_b, m_an_c;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_count <= 0;
         m_ovf   <= 1'b0;
         m_t     <= 0;
         m_seg_a <= 7'h3F;
         m_seg_b <= 7'h3F;
         m_seg_c <= 7'h3F;
         m_an_a  <= 4'b1110;
         m_an_b  <= 4'b1110;
         m_an_c  <= 4'b1110;
      end else begin
         m_count <= next_count(m_count, clr, tick, en);
         m_ovf   <= !clr && tick && en && (m_count == 9999);
         m_t     <= m_t + 1;
         m_an_a  <= exp_an(m_t, 4);
         m_an_b  <= exp_an(m_t, 4);
         m_an_c  <= exp_an(m_t, 1);
         m_seg_a <= exp_seg(m_count, m_t, 4, 1'b1);
         m_seg_b <= exp_seg(m_count, m_t, 4, 1'b0);
         m_seg_c <= exp_seg(m_count, m_t, 1, 1'b1);
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one cycle and compare every output against the model.
   task automatic step();
      @(negedge clk);
      if (rstn) begin
         check("model_digits_a", digits_a, to_bcd(m_count));
         check("model_digits_b", digits_b, to_bcd(m_count));
         check("model_digits_c", digits_c, to_bcd(m_count));
         check("model_ovf", ovf_a, m_ovf);
         check("model_an_a", an_a, m_an_a);
         check("model_an_b", an_b, m_an_b);
         check("model_an_c", an_c, m_an_c);
         check("model_seg_a", seg_a, m_seg_a);
         check("model_seg_b", seg_b, m_seg_b);
         check("model_seg_c", seg_c, m_seg_c);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input bit t, input bit e, input bit c);
      tick = t;
      en   = e;
      clr  = c;
      step();
   endtask

   typedef struct {
      bit          tick;
      bit          en;
      bit          clr;
      logic [15:0] exp_digits;
      bit          exp_ovf;
   } vec_t;

   vec_t       vecs [8];
   logic [3:0] pat  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [3:0] prev;
   logic [6:0] fast_exp;
   bit         found;

   initial begin
      // Vectors applied from count 0000, one cycle each.
      vecs[0] = '{1, 1, 0, 16'h0001, 0};
      vecs[1] = '{1, 0, 0, 16'h0001, 0};
      vecs[2] = '{0, 1, 0, 16'h0001, 0};
      vecs[3] = '{1, 1, 0, 16'h0002, 0};
      vecs[4] = '{1, 1, 1, 16'h0000, 0};
      vecs[5] = '{0, 0, 1, 16'h0000, 0};
      vecs[6] = '{1, 1, 0, 16'h0001, 0};
      vecs[7] = '{1, 1, 0, 16'h0002, 0};

      rstn = 1'b0;
      tick = 1'b0;
      en   = 1'b0;
      clr  = 1'b0;
      repeat (3) step();
      check("rst_digits", digits_a, 16'h0000);
      check("rst_ovf", ovf_a, 1'b0);
      check("rst_seg", seg_a, 7'h3F);
      check("rst_an", an_a, 4'b1110);

      // Scan phase after reset release: an=1110 for 0-4, 1101 for 5-8, 1011 for 9-12.
      rstn = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         step();
         check("rel_an", an_a, (j <= 4) ? 4'b1110 : (j <= 8) ? 4'b1101 : 4'b1011);
      end

      // 12 ticks at random spacing, then 88 back-to-back.
      for (int i = 0; i < 12; i++) begin
         drive(1, 1, 0);
         repeat ($urandom_range(0, 3)) drive(0, 1, 0);
      end
      check("count_12", digits_a, 16'h0012);
      repeat (88) drive(1, 1, 0);
      check("count_100", digits_a, 16'h0100);

      // en low gates ticks.
      repeat (5) drive(1, 0, 0);
      check("en_gate", digits_a, 16'h0100);

      // Up to 9998, then wrap.
      repeat (9898) drive(1, 1, 0);
      check("pre_wrap", digits_a, 16'h9998);
      drive(1, 1, 0);
      check("wrap_9999", digits_a, 16'h9999);
      check("wrap_ovf_early", ovf_a, 1'b0);
      drive(1, 1, 0);
      check("wrap_0000", digits_a, 16'h0000);
      check("wrap_ovf", ovf_a, 1'b1);
      drive(0, 1, 0);
      check("wrap_ovf_clear", ovf_a, 1'b0);
      check("wrap_hold", digits_a, 16'h0000);

      // Repeated wraps give repeated single-cycle pulses.
      for (int w = 0; w < 2; w++) begin
         repeat (9999) drive(1, 1, 0);
         check("rewrap_pre_ovf", ovf_a, 1'b0);
         drive(1, 1, 0);
         check("rewrap_ovf", ovf_a, 1'b1);
         check("rewrap_digits", digits_a, 16'h0000);
      end

      // Clear beats a simultaneous tick.
      drive(0, 1, 1);
      repeat (42) drive(1, 1, 0);
      check("count_42", digits_a, 16'h0042);
      drive(1, 1, 1);
      check("clr_prio_digits", digits_a, 16'h0000);
      check("clr_prio_ovf", ovf_a, 1'b0);

      // Table vectors.
      drive(0, 0, 1);
      for (int v = 0; v < 8; v++) begin
         drive(vecs[v].tick, vecs[v].en, vecs[v].clr);
         check("vec_digits", digits_a, vecs[v].exp_digits);
         check("vec_ovf", ovf_a, vecs[v].exp_ovf);
      end

      // Scan and blanking at 0007.
      drive(0, 0, 1);
      repeat (7) drive(1, 1, 0);
      drive(0, 0, 0);
      found = 1'b0;
      prev  = an_a;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (an_a == 4'b1110 && prev != 4'b1110) found = 1'b1;
         else prev = an_a;
      end
      check("scan_align", found, 1'b1);
      if (found) begin
         for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            check("scan_an", an_a, pat[i / 4]);
            check("scan_seg_lzb1", seg_a, (i < 4) ? 7'h07 : 7'h00);
            check("scan_seg_lzb0", seg_b, (i < 4) ? 7'h07 : 7'h3F);
         end
      end

      // SCAN_DIV=1 at 1234.
      drive(0, 0, 1);
      repeat (1234) drive(1, 1, 0);
      drive(0, 0, 0);
      drive(0, 0, 0);
      check("fast_digits", digits_c, 16'h1234);
      for (int i = 0; i < 8; i++) begin
         prev = an_c;
         step();
         check("fast_rot", an_c, {prev[2:0], prev[3]});
         case (an_c)
            4'b1110: fast_exp = 7'h66;
            4'b1101: fast_exp = 7'h4F;
            4'b1011: fast_exp = 7'h5B;
            4'b0111: fast_exp = 7'h06;
            default: fast_exp = 7'h00;
         endcase
         check("fast_seg", seg_c, fast_exp);
      end

      // Asynchronous reset mid-scan, away from any clock edge.
      @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check("async_digits", digits_a, 16'h0000);
      check("async_ovf", ovf_a, 1'b0);
      check("async_seg", seg_a, 7'h3F);
      check("async_an", an_a, 4'b1110);
      check("async_an_fast", an_c, 4'b1110);
      step();
      rstn = 1'b1;

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 63) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Downstream consumer of the mod-10 prescaler's carry pulse. It accumulates carry pulses into a 4-digit BCD count from 0000 to 9999, wrapping at the top, and flags each wrap. It also drives a time-multiplexed, common-anode 4-digit seven-segment display with optional leading-zero blanking. It is the display/accumulation stage of the counter chain.

## Interface
- SCAN_DIV, default 4: clock cycles each digit stays selected; legal range ≥1.
- LZB, default 1: 1 blanks leading zeros on digits 3..1; 0 shows all digits.

- clk  in  1  single clock; all state updates on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- tick  in  1  count request, sampled every clk edge; each high cycle counts once (fed from the prescaler's carry output).
- en  in  1  count enable; when low, tick is ignored.
- clr  in  1  synchronous clear of the count.
- digits  out  16  BCD count {d3,d2,d1,d0}, where d0 = units in bits [3:0].
- ovf  out  1  one-cycle pulse on a 9999→0000 wrap.
- seg  out  7  segment pattern {g,f,e,d,c,b,a}, active-high.
- an  out  4  digit select, one-hot active-low; an[k] selects dk.

## Operation
- Count update on each edge, in priority order:
  - clr=1: digits←0000, ovf←0.
  - tick&en=1: BCD increment with a ripple carry through all four digits. A digit at 9 goes to 0 and carries into the next digit. At 9999 the count goes to 0000 and ovf←1.
  - otherwise: digits hold, ovf←0.
- Every digit is always a valid BCD value (0–9). No binary values above 9 can occur.
- Scan timer:
  - scan_cnt counts 0..SCAN_DIV-1 and then wraps.
  - On the wrap, idx advances 0→1→2→3→0.
  - With SCAN_DIV=1, idx advances every cycle.
  - en and clr do not affect the scan.
- Display registers update every edge from the pre-edge idx and digits:
  - an ← all ones except bit idx, which is 0.
  - seg ← decode(d[idx]), using 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, gfedcba).
- Blanking with LZB=1: digit k ≥ 1 gives seg=00 when dk through d3 are all zero. d0 is never blanked.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. The scan restarts at idx 0.

## Timing
- Reset values:
  - digits=0000, ovf=0
  - seg=3F, an=1110
  - scan_cnt=0, idx=0
- Count latency: tick&en high in cycle N means digits shows the new value from cycle N+1. ovf is high in cycle N+1 only, aligned with digits=0000.
- Back-to-back ticks count on every cycle, with no lost pulses. Repeated wraps give repeated single-cycle ovf pulses.
- tick&en and clr in the same cycle: the clear wins, the tick is dropped, and ovf=0.
- Scan: idx changes every SCAN_DIV cycles. an and seg follow idx, and digits, with 1 cycle of latency.
- After reset release with SCAN_DIV=4:
  - an=1110 for cycles 0–4.
  - an=1101 for cycles 5–8.
  - an=1011 for cycles 9–12, and the pattern continues.
- A count change shows on seg 1 cycle after digits changes, provided that digit is currently selected.

## Test plan
- Reset: hold rstn low, release → digits=0000, ovf=0, seg=3F, an=1110. Assert rstn asynchronously mid-scan → outputs return to these values without waiting for a clock edge.
- Counting: en=1, 12 single-cycle ticks at random spacing → digits=0012. Then 88 consecutive ticks → digits=0100 with a carry through d1.
- Wrap: with digits=9998, apply 2 consecutive ticks → digits 9999 then 0000. ovf is high only in the cycle after the second tick.
- Priority and gating:
  - en=0 with 5 ticks → digits unchanged.
  - At digits=0042, assert tick=1, en=1, clr=1 together → digits=0000, ovf=0.
- Scan and blanking (SCAN_DIV=4, LZB=1, digits=0007): an cycles 1110, 1101, 1011, 0111 with 4 cycles each. seg = 07, 00, 00, 00. With LZB=0, seg = 07, 3F, 3F, 3F.
- SCAN_DIV=1, digits=1234: an rotates every cycle. seg sequence = 66, 4F, 5B, 06 (d0 to d3), each one cycle behind an's index source.
